// File: rtl/matrix_loader_nxn.sv
// DIM x DIM matrix sequencer: loads A and B from memory, runs an external multiply, stores C.
// Optional memory/engine watchdog is compiled in with `define LOADER_TIMEOUT_EN.
module matrix_loader_nxn #(
  parameter int DIM            = 2,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 15,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [ADDR_W-1:0]          a_address,
  input  logic [ADDR_W-1:0]          b_address,
  input  logic [ADDR_W-1:0]          c_address,
  output logic                       memory_enable,
  output logic                       readWrite,
  output logic [ADDR_W-1:0]          memory_address,
  output logic [DATA_W-1:0]          word_to_memory,
  input  logic [DATA_W-1:0]          word_from_memory,
  input  logic                       memory_done,
  output logic                       mult_enable,
  output logic [DIM*DIM*DATA_W-1:0]  mult_a,
  output logic [DIM*DIM*DATA_W-1:0]  mult_b,
  input  logic [DIM*DIM*DATA_W-1:0]  mult_c,
  input  logic                       mult_done,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int N  = DIM * DIM;
  localparam int KW = $clog2(2 * N + 1);
  localparam logic [KW-1:0] K_N       = KW'(N);
  localparam logic [KW-1:0] K_RD_LAST = KW'(2 * N - 1);
  localparam logic [KW-1:0] K_WR_LAST = KW'(N - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_WR_REQ  = 3'd4;
  localparam logic [2:0] S_WR_WAIT = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]          state_q, state_d, nxt_state_s;
  logic [KW-1:0]       k_q, k_d;
  logic [ADDR_W-1:0]   a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic [N*DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic                mem_en_q, mem_en_d, rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mult_en_q, mult_en_d, busy_q, busy_d, done_q, done_d;
  logic                timeout_s;

  function automatic logic [DATA_W-1:0] elem_at(input logic [N*DATA_W-1:0] vec,
                                                input logic [KW-1:0]       idx);
    elem_at = vec[int'(idx)*DATA_W +: DATA_W];
  endfunction

  // Sequencing and element capture; k counts reads 0..2N-1, then writes 0..N-1.
  always_comb begin
    nxt_state_s = state_q;
    k_d         = k_q;
    a_base_d    = a_base_q;
    b_base_d    = b_base_q;
    c_base_d    = c_base_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          a_base_d    = a_address;
          b_base_d    = b_address;
          c_base_d    = c_address;
          k_d         = '0;
          nxt_state_s = S_RD_REQ;
        end else begin
          nxt_state_s = S_IDLE;
        end
      end
      S_RD_REQ: nxt_state_s = S_RD_WAIT;
      S_RD_WAIT: begin
        if (memory_done) begin
          if (k_q < K_N) begin
            a_d[int'(k_q)*DATA_W +: DATA_W] = word_from_memory;
          end else begin
            b_d[int'(k_q - K_N)*DATA_W +: DATA_W] = word_from_memory;
          end
          k_d         = k_q + KW'(1);
          nxt_state_s = (k_q == K_RD_LAST) ? S_EXEC : S_RD_REQ;
        end else begin
          nxt_state_s = S_RD_WAIT;
        end
      end
      S_EXEC: begin
        if (mult_done) begin
          c_d         = mult_c;
          k_d         = '0;
          nxt_state_s = S_WR_REQ;
        end else begin
          nxt_state_s = S_EXEC;
        end
      end
      S_WR_REQ: nxt_state_s = S_WR_WAIT;
      S_WR_WAIT: begin
        if (memory_done) begin
          k_d         = k_q + KW'(1);
          nxt_state_s = (k_q == K_WR_LAST) ? S_DONE : S_WR_REQ;
        end else begin
          nxt_state_s = S_WR_WAIT;
        end
      end
      S_DONE:  nxt_state_s = S_IDLE;
      default: nxt_state_s = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    state_d   = timeout_s ? S_IDLE : nxt_state_s;
    mem_en_d  = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    rw_d      = (state_d == S_RD_REQ);
    mult_en_d = (state_d == S_EXEC);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    addr_d    = '0;
    wdata_d   = '0;
    case (state_d)
      S_RD_REQ: begin
        if (k_d < K_N) begin
          addr_d = a_base_d + ADDR_W'(k_d);
        end else begin
          addr_d = b_base_d + ADDR_W'(k_d - K_N);
        end
      end
      S_WR_REQ: begin
        addr_d  = c_base_d + ADDR_W'(k_d);
        wdata_d = elem_at(c_d, k_d);
      end
      default: begin
        addr_d  = '0;
        wdata_d = '0;
      end
    endcase
  end

  // State, operand and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      a_base_q  <= '0;
      b_base_q  <= '0;
      c_base_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      mem_en_q  <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mult_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      a_base_q  <= a_base_d;
      b_base_q  <= b_base_d;
      c_base_q  <= c_base_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      mem_en_q  <= mem_en_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mult_en_q <= mult_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            in_wait_s;
  logic            error_q, error_d;

  // A wait that would still be stalled after its last allowed cycle aborts the job.
  always_comb begin
    in_wait_s = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT) || (state_q == S_EXEC);
    timeout_s = in_wait_s && (wd_q == WD_LAST) && (nxt_state_s == state_q);
  end

  // Watchdog restarts on every state change.
  always_comb begin
    wd_d    = (in_wait_s && (state_d == state_q)) ? wd_q + WD_W'(1) : '0;
    error_d = timeout_s;
  end

  // Watchdog and error pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign timeout_s = 1'b0;
  assign error     = 1'b0;
`endif

  assign memory_enable  = mem_en_q;
  assign readWrite      = rw_q;
  assign memory_address = addr_q;
  assign word_to_memory = wdata_q;
  assign mult_enable    = mult_en_q;
  assign mult_a         = a_q;
  assign mult_b         = b_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_matrix_loader_nxn.sv
// Self-checking bench for matrix_loader_nxn: memory and multiply-engine responders, a
// transaction-level model of the expected memory traffic, and one per-cycle compare process.
module tb_matrix_loader_nxn;
  localparam int DIM = 2;
  localparam int N   = DIM * DIM;
  localparam int DW  = 32;
  localparam int AW  = 15;
  localparam int VW  = N * DW;

  logic          clock = 1'b0;
  logic          reset, enable;
  logic [AW-1:0] a_address, b_address, c_address;
  logic          memory_enable, readWrite;
  logic [AW-1:0] memory_address;
  logic [DW-1:0] word_to_memory, word_from_memory;
  logic          memory_done;
  logic          mult_enable, mult_done;
  logic [VW-1:0] mult_a, mult_b, mult_c;
  logic          busy, done, error;

  matrix_loader_nxn #(.DIM(DIM), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .a_address(a_address), .b_address(b_address), .c_address(c_address),
    .memory_enable(memory_enable), .readWrite(readWrite), .memory_address(memory_address),
    .word_to_memory(word_to_memory), .word_from_memory(word_from_memory),
    .memory_done(memory_done), .mult_enable(mult_enable), .mult_a(mult_a), .mult_b(mult_b),
    .mult_c(mult_c), .mult_done(mult_done), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  op_t           exp_q[$];
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [VW-1:0] exp_a, exp_b;
  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, req_cnt = 0, busy_cyc = 0, err_cnt = 0;
  int mem_lat = 1, mult_dly = 0;
  bit mem_mute = 1'b0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // Plain row-major matrix product, truncated to DW bits.
  function automatic logic [VW-1:0] matmul(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] c;
    logic [DW-1:0] s;
    c = '0;
    for (int r = 0; r < DIM; r++)
      for (int col = 0; col < DIM; col++) begin
        s = '0;
        for (int t = 0; t < DIM; t++)
          s = s + a[(r*DIM+t)*DW +: DW] * b[(t*DIM+col)*DW +: DW];
        c[(r*DIM+col)*DW +: DW] = s;
      end
    return c;
  endfunction

  function automatic logic [VW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  // Model: preload memory and list every access the job must make, in order.
  task automatic plan_job(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                          input logic [AW-1:0] cb, input logic [VW-1:0] av, input logic [VW-1:0] bv);
    logic [VW-1:0] cv;
    cv = matmul(av, bv);
    for (int i = 0; i < N; i++) begin
      mem[ab + AW'(i)] = av[i*DW +: DW];
      exp_q.push_back('{1'b1, ab + AW'(i), '0});
    end
    for (int i = 0; i < N; i++) begin
      mem[bb + AW'(i)] = bv[i*DW +: DW];
      exp_q.push_back('{1'b1, bb + AW'(i), '0});
    end
    for (int i = 0; i < N; i++) exp_q.push_back('{1'b0, cb + AW'(i), cv[i*DW +: DW]});
    exp_a = av;
    exp_b = bv;
  endtask

  // Memory responder: done pulse mem_lat cycles after the request strobe.
  initial begin
    logic          rq_rw;
    logic [AW-1:0] rq_addr;
    logic [DW-1:0] rq_data;
    memory_done = 1'b0;
    word_from_memory = '0;
    forever begin
      @(negedge clock);
      memory_done = 1'b0;
      if (memory_enable && !mem_mute) begin
        rq_rw = readWrite; rq_addr = memory_address; rq_data = word_to_memory;
        repeat (mem_lat) @(negedge clock);
        if (rq_rw) word_from_memory = rd_mem(rq_addr);
        else mem[rq_addr] = rq_data;
        memory_done = 1'b1;
      end
    end
  end

  // Multiply engine: answers mult_dly cycles after it sees mult_enable.
  initial begin
    mult_done = 1'b0;
    mult_c = '0;
    forever begin
      @(negedge clock);
      mult_done = 1'b0;
      if (mult_enable) begin
        repeat (mult_dly) @(negedge clock);
        mult_c = matmul(mult_a, mult_b);
        mult_done = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model, sampled just after each rising edge.
  initial begin
    op_t e;
    bit  prev_me = 1'b0, prev_done = 1'b0, prev_mult = 1'b0, prev_err = 1'b0, outstanding = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        exp_q.delete();
        outstanding = 1'b0; prev_me = 1'b0; prev_done = 1'b0; prev_mult = 1'b0; prev_err = 1'b0;
      end else begin
        if (memory_done) outstanding = 1'b0;
        if (memory_enable) begin
          check("strobe_one_cycle", VW'(prev_me), VW'(0));
          check("no_overlap", VW'(outstanding), VW'(0));
          outstanding = 1'b1;
          req_cnt++;
          addr_log.push_back(memory_address);
          if (exp_q.size() == 0) begin
            check("unexpected_request", VW'(memory_address), VW'(0) - VW'(1));
          end else begin
            e = exp_q.pop_front();
            check("req_rw", VW'(readWrite), VW'(e.rw));
            check("req_addr", VW'(memory_address), VW'(e.addr));
            if (!e.rw) check("wr_data", VW'(word_to_memory), VW'(e.data));
          end
        end
        if (mult_enable) begin
          check("mult_a", mult_a, exp_a);
          check("mult_b", mult_b, exp_b);
        end
        if (prev_mult && !mult_enable) check("mult_en_until_done", VW'(mult_done), VW'(1));
        if (prev_done) begin
          check("done_one_cycle", VW'(done), VW'(0));
          check("busy_after_done", VW'(busy), VW'(0));
        end
        if (prev_err) check("error_one_cycle", VW'(error), VW'(0));
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (busy) busy_cyc++;
        prev_me = memory_enable; prev_done = done; prev_mult = mult_enable; prev_err = error;
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] ab, input logic [AW-1:0] bb, input logic [AW-1:0] cb);
    @(negedge clock);
    a_address = ab; b_address = bb; c_address = cb;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, input string nm);
    for (int i = 0; i < 4000 && done_cnt == start_cnt; i++) @(negedge clock);
    check(nm, VW'(done_cnt != start_cnt), VW'(1));
  endtask

  // Full job with a cycle-count check: each access is 1 + latency, EXEC is delay + 1, plus DONE.
  task automatic run_job(input string nm, input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                         input logic [AW-1:0] cb, input logic [VW-1:0] av, input logic [VW-1:0] bv,
                         input int lat, input int dly, input bit mid_pulse);
    int d0, b0;
    mem_lat = lat; mult_dly = dly;
    plan_job(ab, bb, cb, av, bv);
    d0 = done_cnt; b0 = busy_cyc;
    start_job(ab, bb, cb);
    if (mid_pulse) begin
      repeat (5) @(negedge clock);
      enable = 1'b1;
      @(negedge clock);
      enable = 1'b0;
    end
    wait_done(d0, {nm, "_timeout"});
    repeat (30) @(negedge clock);
    check({nm, "_one_done"}, VW'(done_cnt - d0), VW'(1));
    check({nm, "_all_ops"}, VW'(exp_q.size()), VW'(0));
    check({nm, "_busy_cycles"}, VW'(busy_cyc - b0), VW'(3 * N * (1 + lat) + (dly + 1) + 1));
    check({nm, "_idle"}, VW'(busy), VW'(0));
  endtask

  initial begin
    int r0, d0, e0;
    reset = 1'b1; enable = 1'b0;
    a_address = '0; b_address = '0; c_address = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs", VW'({memory_enable, readWrite, memory_address, word_to_memory,
                                mult_enable, busy, done, error}), VW'(0));
    check("reset_mult_ab", mult_a | mult_b, VW'(0));
    reset = 1'b0;
    @(negedge clock);

    // 1: basic job, latency 1
    run_job("t1", 15'h0010, 15'h0020, 15'h0030, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1, 0, 1'b0);
    check("t1_c0", VW'(rd_mem(15'h0030)), VW'(19));
    check("t1_c1", VW'(rd_mem(15'h0031)), VW'(22));
    check("t1_c2", VW'(rd_mem(15'h0032)), VW'(43));
    check("t1_c3", VW'(rd_mem(15'h0033)), VW'(50));

    // 2: same data, latency 5
    run_job("t2", 15'h0010, 15'h0020, 15'h0040, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 5, 3, 1'b0);
    check("t2_c0", VW'(rd_mem(15'h0040)), VW'(19));
    check("t2_c3", VW'(rd_mem(15'h0043)), VW'(50));

    // 3: A base wraps past the top of the address space
    r0 = addr_log.size();
    run_job("t3", 15'h7FFE, 15'h0100, 15'h0200, pack4(9, 8, 7, 6), pack4(1, 0, 0, 1), 1, 1, 1'b0);
    check("t3_addr0", VW'(addr_log[r0]),     VW'(15'h7FFE));
    check("t3_addr1", VW'(addr_log[r0 + 1]), VW'(15'h7FFF));
    check("t3_addr2", VW'(addr_log[r0 + 2]), VW'(15'h0000));
    check("t3_addr3", VW'(addr_log[r0 + 3]), VW'(15'h0001));
    check("t3_c1", VW'(rd_mem(15'h0201)), VW'(8));

    // 5: stray enable mid-job, engine answers 20 cycles late
    run_job("t5", 15'h0300, 15'h0310, 15'h0320, pack4(2, 0, 0, 2), pack4(3, 4, 5, 6), 1, 20, 1'b1);
    check("t5_c2", VW'(rd_mem(15'h0322)), VW'(10));

    // 4: reset during the third read; the abandoned memory_done arrives afterwards
    mem_lat = 5; mult_dly = 0;
    plan_job(15'h0400, 15'h0410, 15'h0420, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2));
    r0 = req_cnt; d0 = done_cnt;
    start_job(15'h0400, 15'h0410, 15'h0420);
    for (int i = 0; i < 200 && req_cnt < r0 + 3; i++) @(negedge clock);
    check("t4_third_read", VW'(req_cnt - r0), VW'(3));
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check("t4_idle_outputs", VW'({memory_enable, busy, done, mult_enable, readWrite,
                                    memory_address, word_to_memory}) | mult_a | mult_b, VW'(0));
    end
    check("t4_no_done", VW'(done_cnt - d0), VW'(0));
    check("t4_no_new_req", VW'(req_cnt - r0), VW'(3));

    // 6: memory never answers
    mem_mute = 1'b1; mem_lat = 1;
    plan_job(15'h0500, 15'h0510, 15'h0520, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4));
    r0 = req_cnt; d0 = done_cnt; e0 = err_cnt;
    start_job(15'h0500, 15'h0510, 15'h0520);
    repeat (40) @(negedge clock);
    check("t6_one_req", VW'(req_cnt - r0), VW'(1));
    check("t6_no_done", VW'(done_cnt - d0), VW'(0));
`ifdef LOADER_TIMEOUT_EN
    check("t6_error_pulse", VW'(err_cnt - e0), VW'(1));
    check("t6_idle", VW'(busy), VW'(0));
`else
    check("t6_no_error", VW'(err_cnt - e0), VW'(0));
    check("t6_still_busy", VW'(busy), VW'(1));
`endif
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mem_mute = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_reset_idle", VW'(busy), VW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
